// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, aligns load data and drives the GPR write port.
// Optional trace outputs are compiled in with `define DEBUG_TRACE_EN.
module wb_stage #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ms_to_ws_valid,
    output logic              o_ws_allowin,
    input  logic [PC_W-1:0]   i_ms_pc,
    input  logic              i_ms_rf_we,
    input  logic [4:0]        i_ms_rf_waddr,
    input  logic [DATA_W-1:0] i_ms_result,
    input  logic [2:0]        i_ms_load_op,
    input  logic              i_data_ok,
    input  logic [DATA_W-1:0] i_data_rdata,
    input  logic              i_ws_flush,
    output logic              o_rf_we,
    output logic [4:0]        o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_ws_fwd_valid,
    output logic [4:0]        o_ws_busy_addr,
    output logic              o_ws_data_wait,
    output logic [DATA_W-1:0] o_ws_fwd_data
`ifdef DEBUG_TRACE_EN
    ,
    output logic [PC_W-1:0]   o_debug_wb_pc,
    output logic [3:0]        o_debug_wb_rf_we,
    output logic [4:0]        o_debug_wb_rf_wnum,
    output logic [DATA_W-1:0] o_debug_wb_rf_wdata
`endif
);

    localparam logic [2:0] LdNone = 3'd0;
    localparam logic [2:0] LdB    = 3'd1;
    localparam logic [2:0] LdH    = 3'd2;
    localparam logic [2:0] LdW    = 3'd3;
    localparam logic [2:0] LdBu   = 3'd4;
    localparam logic [2:0] LdHu   = 3'd5;

    logic              r_ws_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_rf_we;
    logic [4:0]        r_waddr;
    logic [DATA_W-1:0] r_result;
    logic [2:0]        r_load_op;
    logic [DATA_W-1:0] r_rdata;
    logic              r_data_got;
    logic              r_drop_pending;

    logic              w_ms_load_op;
    logic [2:0]        w_ms_op_norm;
    logic              w_is_load;
    logic              w_resp;
    logic              w_ready_go;
    logic              w_allowin;
    logic              w_accept;
    logic              w_capture;
    logic              w_drop_set;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_wdata;

    // Reserved load encodings retire as plain ALU results.
    assign w_ms_load_op = (i_ms_load_op >= LdB) && (i_ms_load_op <= LdHu);
    assign w_ms_op_norm = w_ms_load_op ? i_ms_load_op : LdNone;

    // A response arriving while drop_pending belongs to a flushed load, never to ours.
    assign w_resp     = i_data_ok & ~r_drop_pending;
    assign w_is_load  = (r_load_op != LdNone);
    assign w_ready_go = r_ws_valid & (~w_is_load | r_data_got | w_resp);
    assign w_allowin  = ~r_ws_valid | w_ready_go;
    assign w_accept   = i_ms_to_ws_valid & w_allowin & ~i_ws_flush;
    assign w_capture  = r_ws_valid & w_is_load & ~r_data_got & w_resp;
    assign w_drop_set = i_ws_flush & r_ws_valid & w_is_load & ~r_data_got & ~w_resp;
    assign w_wr_ok    = r_rf_we & (r_waddr != 5'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ws_valid     <= 1'b0;
            r_data_got     <= 1'b0;
            r_drop_pending <= 1'b0;
        end else begin
            r_drop_pending <= (r_drop_pending & ~i_data_ok) | w_drop_set;
            if (i_ws_flush) begin
                r_ws_valid <= 1'b0;
                r_data_got <= 1'b0;
            end else if (w_accept) begin
                r_ws_valid <= 1'b1;
                r_data_got <= 1'b0;
            end else begin
                if (w_ready_go) begin
                    r_ws_valid <= 1'b0;
                end
                if (w_capture) begin
                    r_data_got <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_pc      <= i_ms_pc;
            r_rf_we   <= i_ms_rf_we;
            r_waddr   <= i_ms_rf_waddr;
            r_result  <= i_ms_result;
            r_load_op <= w_ms_op_norm;
        end
        if (w_capture) begin
            r_rdata <= i_data_rdata;
        end
    end

    // Same-cycle response is used directly so the load retires without an extra cycle.
    always_comb begin
        w_word = r_data_got ? r_rdata : i_data_rdata;
        w_byte = w_word[7:0];
        unique case (r_result[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
        endcase
        w_half = r_result[1] ? w_word[31:16] : w_word[15:0];
        unique case (r_load_op)
            LdB:     w_wdata = {{24{w_byte[7]}}, w_byte};
            LdBu:    w_wdata = {24'd0, w_byte};
            LdH:     w_wdata = {{16{w_half[15]}}, w_half};
            LdHu:    w_wdata = {16'd0, w_half};
            LdW:     w_wdata = w_word;
            default: w_wdata = r_result;
        endcase
    end

    assign o_ws_allowin   = w_allowin;
    assign o_rf_we        = w_ready_go & w_wr_ok & ~i_ws_flush;
    assign o_rf_waddr     = r_waddr;
    assign o_rf_wdata     = w_wdata;
    assign o_ws_fwd_data  = w_wdata;
    assign o_ws_fwd_valid = w_ready_go & w_wr_ok;
    assign o_ws_busy_addr = (r_ws_valid & r_rf_we) ? r_waddr : 5'd0;
    assign o_ws_data_wait = r_ws_valid & w_is_load & ~w_ready_go;

`ifdef DEBUG_TRACE_EN
    assign o_debug_wb_pc       = i_rst ? '0 : r_pc;
    assign o_debug_wb_rf_we    = i_rst ? 4'd0 : {4{o_rf_we}};
    assign o_debug_wb_rf_wnum  = i_rst ? 5'd0 : r_waddr;
    assign o_debug_wb_rf_wdata = i_rst ? '0 : w_wdata;
`else
    logic w_unused_pc;
    assign w_unused_pc = ^r_pc;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios then randomized traffic vs a reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst = 1'b1;
    logic        i_ms_to_ws_valid = 1'b0;
    logic        o_ws_allowin;
    logic [31:0] i_ms_pc = '0;
    logic        i_ms_rf_we = 1'b0;
    logic [4:0]  i_ms_rf_waddr = '0;
    logic [31:0] i_ms_result = '0;
    logic [2:0]  i_ms_load_op = '0;
    logic        i_data_ok = 1'b0;
    logic [31:0] i_data_rdata = '0;
    logic        i_ws_flush = 1'b0;
    logic        o_rf_we;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_ws_fwd_valid;
    logic [4:0]  o_ws_busy_addr;
    logic        o_ws_data_wait;
    logic [31:0] o_ws_fwd_data;
`ifdef DEBUG_TRACE_EN
    logic [31:0] o_debug_wb_pc;
    logic [3:0]  o_debug_wb_rf_we;
    logic [4:0]  o_debug_wb_rf_wnum;
    logic [31:0] o_debug_wb_rf_wdata;
`endif

    wb_stage dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_ms_to_ws_valid(i_ms_to_ws_valid),
        .o_ws_allowin    (o_ws_allowin),
        .i_ms_pc         (i_ms_pc),
        .i_ms_rf_we      (i_ms_rf_we),
        .i_ms_rf_waddr   (i_ms_rf_waddr),
        .i_ms_result     (i_ms_result),
        .i_ms_load_op    (i_ms_load_op),
        .i_data_ok       (i_data_ok),
        .i_data_rdata    (i_data_rdata),
        .i_ws_flush      (i_ws_flush),
        .o_rf_we         (o_rf_we),
        .o_rf_waddr      (o_rf_waddr),
        .o_rf_wdata      (o_rf_wdata),
        .o_ws_fwd_valid  (o_ws_fwd_valid),
        .o_ws_busy_addr  (o_ws_busy_addr),
        .o_ws_data_wait  (o_ws_data_wait),
        .o_ws_fwd_data   (o_ws_fwd_data)
`ifdef DEBUG_TRACE_EN
        ,
        .o_debug_wb_pc      (o_debug_wb_pc),
        .o_debug_wb_rf_we   (o_debug_wb_rf_we),
        .o_debug_wb_rf_wnum (o_debug_wb_rf_wnum),
        .o_debug_wb_rf_wdata(o_debug_wb_rf_wdata)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Memory model: in-order responses, each with a countdown before it is returned.
    typedef struct {
        logic [31:0] data;
        int          delay;
    } resp_t;
    resp_t mem_q[$];

    typedef struct {
        logic [31:0] pc;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] res;
        logic [2:0]  op;
    } ins_t;

    ins_t        m_ins;
    bit          m_valid = 1'b0;
    int          drop_cnt = 0;
    bit          dir_mode = 1'b0;
    logic [31:0] dir_data = '0;
    int          dir_delay = 0;

    int          wr_cnt;
    logic [31:0] wr_data;
    logic [4:0]  wr_addr;
    int          wait_cnt;
    int          allow_low;
    logic [31:0] dbg_pc;
    logic [4:0]  dbg_num;
    logic [31:0] dbg_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_load(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    // Load value from arithmetic on the whole word rather than bit slicing.
    function automatic logic [31:0] ld_value(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned b;
        int unsigned h;
        int          s;
        b = (word >> (8 * int'(addr[1:0]))) & 32'hFF;
        h = (word >> (16 * int'(addr[1]))) & 32'hFFFF;
        case (op)
            3'd1: begin s = int'(b); if (b > 127) s = s - 256; return s; end
            3'd2: begin s = int'(h); if (h > 32767) s = s - 65536; return s; end
            3'd3: return word;
            3'd4: return b;
            3'd5: return h;
            default: return addr;
        endcase
    endfunction

    task automatic clear_obs();
        wr_cnt = 0; wr_data = '0; wr_addr = '0; wait_cnt = 0; allow_low = 0;
        dbg_pc = '0; dbg_num = '0; dbg_we = '0;
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+4, advance the model at the edge.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit we, input logic [4:0] wa,
                         input logic [31:0] res, input logic [2:0] op, input bit fl);
        bit          fire;
        bit          mine;
        bit          done;
        bit          e_we;
        bit          e_fwd;
        bit          e_allow;
        logic [31:0] val;
        resp_t       r;
        i_ms_to_ws_valid = v; i_ms_pc = pc; i_ms_rf_we = we; i_ms_rf_waddr = wa;
        i_ms_result = res; i_ms_load_op = op; i_ws_flush = fl;
        fire = (mem_q.size() > 0) && (mem_q[0].delay == 0);
        i_data_ok = fire;
        i_data_rdata = fire ? mem_q[0].data : $urandom;
        #3;
        mine    = fire && (drop_cnt == 0);
        done    = m_valid && (!is_load(m_ins.op) || mine);
        val     = is_load(m_ins.op) ? ld_value(m_ins.op, m_ins.res, i_data_rdata) : m_ins.res;
        e_allow = !m_valid || done;
        e_fwd   = done && m_ins.we && (m_ins.wa != 5'd0);
        e_we    = e_fwd && !fl;
        chk("allowin", 32'(o_ws_allowin), 32'(e_allow));
        chk("rf_we", 32'(o_rf_we), 32'(e_we));
        chk("fwd_valid", 32'(o_ws_fwd_valid), 32'(e_fwd));
        chk("data_wait", 32'(o_ws_data_wait), 32'(m_valid && is_load(m_ins.op) && !done));
        chk("busy_addr", 32'(o_ws_busy_addr), (m_valid && m_ins.we) ? 32'(m_ins.wa) : 32'd0);
        if (e_we) begin
            chk("rf_waddr", 32'(o_rf_waddr), 32'(m_ins.wa));
            chk("rf_wdata", o_rf_wdata, val);
        end
        if (e_fwd) chk("fwd_data", o_ws_fwd_data, val);
`ifdef DEBUG_TRACE_EN
        chk("dbg_we", 32'(o_debug_wb_rf_we), e_we ? 32'hF : 32'h0);
        if (e_we) begin
            chk("dbg_pc", o_debug_wb_pc, m_ins.pc);
            chk("dbg_wnum", 32'(o_debug_wb_rf_wnum), 32'(m_ins.wa));
            chk("dbg_wdata", o_debug_wb_rf_wdata, val);
        end
        if (o_debug_wb_rf_we != 4'h0) begin
            dbg_pc = o_debug_wb_pc; dbg_num = o_debug_wb_rf_wnum; dbg_we = 32'(o_debug_wb_rf_we);
        end
`endif
        if (o_rf_we) begin wr_cnt++; wr_data = o_rf_wdata; wr_addr = o_rf_waddr; end
        if (o_ws_data_wait) wait_cnt++;
        if (!o_ws_allowin) allow_low++;
        @(posedge clk);
        if (fire) void'(mem_q.pop_front());
        else if (mem_q.size() > 0) mem_q[0].delay--;
        if (fire && drop_cnt > 0) drop_cnt--;
        if (fl) begin
            if (m_valid && is_load(m_ins.op) && !mine) drop_cnt++;
            m_valid = 1'b0;
        end else if (v && e_allow) begin
            m_ins = '{pc: pc, we: we, wa: wa, res: res, op: op};
            m_valid = 1'b1;
            if (is_load(op)) begin
                r.data  = dir_mode ? dir_data : $urandom;
                r.delay = dir_mode ? dir_delay : int'($urandom_range(0, 3));
                mem_q.push_back(r);
            end
        end else if (done) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Memory side resets together with the stage, so its queue is cleared too.
    task automatic do_reset(input int n);
        i_rst = 1'b1; i_ms_to_ws_valid = 1'b0; i_data_ok = 1'b0; i_ws_flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        mem_q.delete(); m_valid = 1'b0; drop_cnt = 0;
        chk("rst_allowin", 32'(o_ws_allowin), 32'd1);
        chk("rst_rf_we", 32'(o_rf_we), 32'd0);
        chk("rst_busy", 32'(o_ws_busy_addr), 32'd0);
        chk("rst_wait", 32'(o_ws_data_wait), 32'd0);
        chk("rst_fwd", 32'(o_ws_fwd_valid), 32'd0);
`ifdef DEBUG_TRACE_EN
        chk("rst_dbg_we", 32'(o_debug_wb_rf_we), 32'd0);
        chk("rst_dbg_pc", o_debug_wb_pc, 32'd0);
        chk("rst_dbg_wdata", o_debug_wb_rf_wdata, 32'd0);
`endif
        i_rst = 1'b0;
    endtask

    initial begin
        clear_obs();
        do_reset(2);
        idle(2);

        // ALU write to r5, then the same op to r0.
        clear_obs();
        cycle(1'b1, 32'h1c00_0000, 1'b1, 5'd5, 32'h1234_5678, 3'd0, 1'b0);
        idle(2);
        chk("alu_cnt", 32'(wr_cnt), 32'd1);
        chk("alu_data", wr_data, 32'h1234_5678);
        chk("alu_addr", 32'(wr_addr), 32'd5);
        clear_obs();
        cycle(1'b1, 32'h1c00_0004, 1'b1, 5'd0, 32'h1234_5678, 3'd0, 1'b0);
        idle(2);
        chk("r0_cnt", 32'(wr_cnt), 32'd0);

        // ld.b at byte 3 with a late response, then ld.hu on the upper half.
        dir_mode = 1'b1; dir_data = 32'h80FF_0000; dir_delay = 3;
        clear_obs();
        cycle(1'b1, 32'h1c00_0008, 1'b1, 5'd6, 32'h0000_1003, 3'd1, 1'b0);
        idle(6);
        chk("ldb_wait", 32'(wait_cnt), 32'd3);
        chk("ldb_allow_low", 32'(allow_low), 32'd3);
        chk("ldb_data", wr_data, 32'hFFFF_FF80);
        dir_delay = 0;
        clear_obs();
        cycle(1'b1, 32'h1c00_000c, 1'b1, 5'd7, 32'h0000_1002, 3'd5, 1'b0);
        idle(3);
        chk("ldhu_data", wr_data, 32'h0000_80FF);
        chk("ldhu_cnt", 32'(wr_cnt), 32'd1);

        // Back-to-back ALU writes.
        clear_obs();
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b1, 32'h1c00_0100 + 32'(4 * i), 1'b1, 5'(i), 32'(i * 16), 3'd0, 1'b0);
        end
        idle(1);
        chk("b2b_cnt", 32'(wr_cnt), 32'd3);
        chk("b2b_allow", 32'(allow_low), 32'd0);
        chk("b2b_last", 32'(wr_addr), 32'd3);

        // Flush a waiting load, then a new ld.w must skip the stale response.
        clear_obs();
        dir_data = 32'hDEAD_BEEF; dir_delay = 3;
        cycle(1'b1, 32'h1c00_0200, 1'b1, 5'd9, 32'h0000_2000, 3'd3, 1'b0);
        idle(1);
        cycle(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
        dir_data = 32'h0000_0042; dir_delay = 0;
        cycle(1'b1, 32'h1c00_0204, 1'b1, 5'd10, 32'h0000_2004, 3'd3, 1'b0);
        idle(5);
        chk("flush_cnt", 32'(wr_cnt), 32'd1);
        chk("flush_data", wr_data, 32'h0000_0042);
        chk("flush_addr", 32'(wr_addr), 32'd10);

        // Reset while a load waits.
        dir_data = 32'h1111_2222; dir_delay = 3;
        cycle(1'b1, 32'h1c00_0300, 1'b1, 5'd11, 32'h0000_3000, 3'd3, 1'b0);
        idle(1);
        do_reset(1);
        clear_obs();
        idle(6);
        chk("rst_load_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_load_wait", 32'(wait_cnt), 32'd0);
        dir_mode = 1'b0;

`ifdef DEBUG_TRACE_EN
        clear_obs();
        cycle(1'b1, 32'h1c00_0400, 1'b1, 5'd7, 32'h0000_00A5, 3'd0, 1'b0);
        idle(1);
        chk("dbg_trace_we", dbg_we, 32'hF);
        chk("dbg_trace_num", 32'(dbg_num), 32'd7);
        chk("dbg_trace_pc", dbg_pc, 32'h1c00_0400);
`endif

        // Random traffic; a new flush is only issued when no stale response is owed.
        for (int i = 0; i < 600; i++) begin
            bit fl;
            fl = (drop_cnt == 0) && ($urandom_range(0, 15) == 0);
            cycle($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)), fl);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the five-stage LoongArch pipeline; sits directly upstream of the general register file and drives its single write port.
- Accepts retiring instructions from the MEM stage through a valid/allowin handshake.
- Waits for and aligns load response data, and exposes forwarding/interlock information to the decode stage.
- Writes the register file exactly once per retired instruction.

Parameters:
- PC_W, 32, width of PC field.
- DATA_W, 32, datapath width; only 32 supported.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- ms_to_ws_valid  input  1  MEM stage holds an instruction for WB.
- ws_allowin  output  1  WB can accept this cycle.
- ms_pc  input  32  PC of incoming instruction.
- ms_rf_we  input  1  instruction writes a GPR.
- ms_rf_waddr  input  5  destination GPR.
- ms_result  input  32  ALU/CSR result (for loads: effective address).
- ms_load_op  input  3  0 none, 1 ld.b, 2 ld.h, 3 ld.w, 4 ld.bu, 5 ld.hu; 6-7 reserved, treated as 0.
- data_ok  input  1  load response valid (one-cycle pulse).
- data_rdata  input  32  load response word.
- ws_flush  input  1  exception/ertn flush; kills WB contents.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  5  register-file write address.
- rf_wdata  output  32  register-file write data.
- ws_fwd_valid  output  1  WB holds a pending GPR write with final data.
- ws_busy_addr  output  5  destination of WB instruction (0 if none).
- ws_data_wait  output  1  WB holds a load still awaiting data (decode must stall, not forward).
- ws_fwd_data  output  32  forwarding value (equals rf_wdata).

Behaviour:
- Registers: ws_valid, pc, rf_we, waddr, result, load_op, buffered rdata, data_got, drop_pending.
- Reset (rst=1 at posedge): ws_valid=0, data_got=0, drop_pending=0. Hence rf_we=0, ws_fwd_valid=0, ws_data_wait=0, ws_busy_addr=0, ws_allowin=1.
- ws_ready_go = ws_valid & (load_op==0 | data_got | data_ok).
- ws_allowin = !ws_valid | ws_ready_go.
- Accept on posedge when ms_to_ws_valid & ws_allowin & !ws_flush: latch all ms_* fields, clear data_got.
- If ready_go and nothing accepted, ws_valid clears.
- Load wait:
  - data_ok with ws_valid & load_op!=0 & !data_got & !drop_pending: capture data_rdata, set data_got.
  - Same-cycle data_ok completes the instruction that cycle (rdata used combinationally).
- Responses are in order, at most one outstanding. data_ok with no waiting load and drop_pending=0 is ignored.
- Alignment uses result[1:0]:
  - ld.b/ld.bu select byte result[1:0], sign/zero-extend.
  - ld.h/ld.hu select halfword result[1], sign/zero-extend; result[0] ignored (ALE raised upstream).
  - ld.w passes the word.
  - Non-load: rf_wdata = result.
- rf_we = ws_valid & ws_ready_go & rf_we_latched & (waddr!=0) & !ws_flush. High for exactly one cycle per instruction.
- rf_waddr/rf_wdata are valid whenever rf_we=1; otherwise don't-care but stable.
- ws_busy_addr = (ws_valid & rf_we_latched) ? waddr : 0.
- ws_fwd_valid = ws_valid & rf_we_latched & waddr!=0 & ws_ready_go.
- ws_data_wait = ws_valid & load_op!=0 & !ws_ready_go.
- Flush:
  - ws_flush=1 at posedge clears ws_valid and data_got, and suppresses rf_we that cycle.
  - If a load was waiting without data (and data_ok not present that cycle), set drop_pending. The next data_ok is consumed silently and clears drop_pending.
  - While drop_pending=1, a newly accepted load must not take that response.
- Back-to-back: a new instruction may be accepted in the same cycle the previous one writes back (full throughput for non-loads).
- rst mid-load: all state cleared, drop_pending=0. The memory side is reset concurrently.

Optional Feature:
- Macro DEBUG_TRACE_EN.
- Defined: add outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0].
  - debug_wb_rf_we = {4{rf_we}}; other outputs mirror pc/rf_waddr/rf_wdata.
  - All zero during reset.
- Undefined: these ports and their logic are absent; no other behaviour changes.

Test Plan:
- Reset then idle: rst=1 two cycles -> rf_we=0, ws_allowin=1, ws_busy_addr=0.
- ALU op, waddr=5, result=0x1234_5678 -> one cycle later rf_we=1, rf_waddr=5, rf_wdata=0x12345678 for exactly 1 cycle. Same op with waddr=0 -> rf_we never asserted.
- ld.b, result[1:0]=3, data_ok 3 cycles late with rdata=0x80FF_0000:
  - ws_allowin=0 and ws_data_wait=1 while waiting.
  - Then rf_wdata=0xFFFF_FF80.
  - ld.hu with result[1]=1 on the same word -> 0x0000_80FF.
- Back-to-back ALU writes to r1, r2, r3 each cycle -> three consecutive rf_we pulses, no bubbles, ws_allowin stays 1.
- Load waiting, ws_flush pulsed, next cycle new ld.w accepted, then two data_ok pulses (0xDEAD_BEEF, 0x0000_0042) -> first dropped, rf_wdata=0x00000042, no write for the flushed load.
- With DEBUG_TRACE_EN: ALU write r7=0xA5 -> debug_wb_rf_we=4'hF, debug_wb_rf_wnum=7, debug_wb_pc equals the instruction's PC.
